// File: rtl/vertex_shader_pkg.sv
// Shared types for the vertex shader: vertex record layout, screen/depth widths,
// FSM state encoding and the screen-coordinate saturation helper.
package vertex_shader_pkg;

    localparam int unsigned IDX_W   = 20;   // vertex SRAM word address
    localparam int unsigned COORD_W = 16;   // model-space x/y/z
    localparam int unsigned SCR_W   = 12;   // screen x/y
    localparam int unsigned DEPTH_W = 21;   // depth
    localparam int unsigned COLOR_W = 24;   // colour
    localparam int unsigned REC_W   = 3 * COORD_W + COLOR_W;
    localparam int unsigned NUM_VTX = 3;
    localparam int unsigned PROD_W  = 32;   // coord * scale
    localparam int unsigned SUM_W   = 33;   // scaled coord + offset
    localparam int unsigned DSUM_W  = DEPTH_W + 1;
    localparam int          SCR_MAX = (1 << SCR_W) - 1;

    // Vertex SRAM word, MSB first: {x s16, y s16, z u16, color 24}
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
        logic [COLOR_W-1:0] color;
    } vtx_rec_t;

    typedef struct packed {
        logic [SCR_W-1:0]   sx;
        logic [SCR_W-1:0]   sy;
        logic [DEPTH_W-1:0] depth;
        logic [COLOR_W-1:0] color;
    } shaded_vtx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_XFORM = 2'd2,
        ST_READY = 2'd3
    } vs_state_e;

    // Clamp a signed screen-space sum into [0, SCR_MAX]
    function automatic logic [SCR_W-1:0] sat_screen(input logic signed [SUM_W-1:0] v);
        if (v < SUM_W'(0))
            return '0;
        else if (v > SUM_W'(SCR_MAX))
            return '1;
        else
            return SCR_W'(v);
    endfunction

endpackage

// File: rtl/vs_viewport_map.sv
// Combinational viewport mapping for one vertex.
//   vtx    : raw vertex record from SRAM
//   shaded : saturated screen x/y, saturated biased depth, colour passthrough
module vs_viewport_map
    import vertex_shader_pkg::*;
#(
    parameter int          X_SCALE    = 256,
    parameter int          Y_SCALE    = 256,
    parameter int unsigned X_OFF      = 320,
    parameter int unsigned Y_OFF      = 240,
    parameter int unsigned DEPTH_BIAS = 0
) (
    input  vtx_rec_t    vtx,
    output shaded_vtx_t shaded
);

    logic signed [PROD_W-1:0] x_prod;
    logic signed [PROD_W-1:0] y_prod;
    logic signed [SUM_W-1:0]  x_sum;
    logic signed [SUM_W-1:0]  y_sum;
    logic [DSUM_W-1:0]        d_sum;

    // Q8.8 scale: multiply, drop 8 fraction bits arithmetically, add offset
    always_comb begin
        x_prod = PROD_W'($signed(vtx.x)) * PROD_W'(X_SCALE);
        y_prod = PROD_W'($signed(vtx.y)) * PROD_W'(Y_SCALE);
        x_sum  = (SUM_W'(x_prod) >>> 8) + $signed(SUM_W'(X_OFF));
        y_sum  = (SUM_W'(y_prod) >>> 8) + $signed(SUM_W'(Y_OFF));
        d_sum  = DSUM_W'(vtx.z) + DSUM_W'(DEPTH_BIAS);

        shaded.sx    = sat_screen(x_sum);
        shaded.sy    = sat_screen(y_sum);
        shaded.depth = d_sum[DEPTH_W] ? '1 : d_sum[DEPTH_W-1:0];
        shaded.color = vtx.color;
    end

endmodule

// File: rtl/vertex_shader.sv
// Vertex shader: collects three vertex indices, fetches each record from vertex
// SRAM, maps them to screen space and presents the triangle with data_ready.
//   clk, rst                 : clock, async active-high reset
//   to_shader_valid/_info    : vertex index strobe and SRAM word address
//   sram_vtx_rd/addr/rdata   : vertex SRAM read port (rdata SRAM_LAT after rd)
//   verticeN_*_update        : shaded triangle, valid while data_ready=1
//   proto_err                : sticky, index arrived with three already issued
module vertex_shader
    import vertex_shader_pkg::*;
#(
    parameter int unsigned SRAM_LAT   = 2,
    parameter int          X_SCALE    = 256,
    parameter int          Y_SCALE    = 256,
    parameter int unsigned X_OFF      = 320,
    parameter int unsigned Y_OFF      = 240,
    parameter int unsigned DEPTH_BIAS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               to_shader_valid,
    input  logic [IDX_W-1:0]   to_shader_vertice_info,
    output logic               sram_vtx_rd,
    output logic [IDX_W-1:0]   sram_vtx_addr,
    input  logic [REC_W-1:0]   sram_vtx_rdata,
    output logic [SCR_W-1:0]   vertice1_x_update,
    output logic [SCR_W-1:0]   vertice1_y_update,
    output logic [DEPTH_W-1:0] vertice1_depth_update,
    output logic [COLOR_W-1:0] vertice1_color_update,
    output logic [SCR_W-1:0]   vertice2_x_update,
    output logic [SCR_W-1:0]   vertice2_y_update,
    output logic [DEPTH_W-1:0] vertice2_depth_update,
    output logic [COLOR_W-1:0] vertice2_color_update,
    output logic [SCR_W-1:0]   vertice3_x_update,
    output logic [SCR_W-1:0]   vertice3_y_update,
    output logic [DEPTH_W-1:0] vertice3_depth_update,
    output logic [COLOR_W-1:0] vertice3_color_update,
    output logic               data_ready,
    output logic               proto_err
);

    localparam int unsigned TAG_PIPE_W = 2 * SRAM_LAT;

    vs_state_e                 state;
    logic [1:0]                issue_cnt;
    logic [1:0]                cap_cnt;
    logic [1:0]                rd_slot;
    logic [SRAM_LAT-1:0]       tag_vld;
    logic [SRAM_LAT-1:0][1:0]  tag_slot;
    vtx_rec_t                  slot_q [NUM_VTX];
    shaded_vtx_t               map_c  [NUM_VTX];
    shaded_vtx_t               out_q  [NUM_VTX];

    // Three parallel datapaths so XFORM completes in a single cycle
    for (genvar g = 0; g < NUM_VTX; g++) begin : g_map
        vs_viewport_map #(
            .X_SCALE   (X_SCALE),
            .Y_SCALE   (Y_SCALE),
            .X_OFF     (X_OFF),
            .Y_OFF     (Y_OFF),
            .DEPTH_BIAS(DEPTH_BIAS)
        ) u_map (
            .vtx   (slot_q[g]),
            .shaded(map_c[g])
        );
    end

    // Control FSM, SRAM issue, tag pipe and slot capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            issue_cnt     <= '0;
            cap_cnt       <= '0;
            rd_slot       <= '0;
            tag_vld       <= '0;
            tag_slot      <= '0;
            sram_vtx_rd   <= 1'b0;
            sram_vtx_addr <= '0;
            data_ready    <= 1'b0;
            proto_err     <= 1'b0;
            slot_q        <= '{default: '0};
            out_q         <= '{default: '0};
        end else begin
            sram_vtx_rd <= 1'b0;

            // Tag pipe is fed from the registered strobe, so its tail lines up with rdata
            tag_vld  <= SRAM_LAT'({tag_vld, sram_vtx_rd});
            tag_slot <= TAG_PIPE_W'({tag_slot, rd_slot});
            if (tag_vld[SRAM_LAT-1]) begin
                slot_q[tag_slot[SRAM_LAT-1]] <= sram_vtx_rdata;
                cap_cnt                      <= cap_cnt + 2'd1;
            end

            case (state)
                ST_IDLE, ST_READY: begin
                    // First index of a new triangle; old outputs stay until XFORM
                    if (to_shader_valid) begin
                        sram_vtx_rd   <= 1'b1;
                        sram_vtx_addr <= to_shader_vertice_info;
                        rd_slot       <= 2'd0;
                        issue_cnt     <= 2'd1;
                        cap_cnt       <= 2'd0;
                        data_ready    <= 1'b0;
                        state         <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (to_shader_valid) begin
                        if (issue_cnt != 2'd3) begin
                            sram_vtx_rd   <= 1'b1;
                            sram_vtx_addr <= to_shader_vertice_info;
                            rd_slot       <= issue_cnt;
                            issue_cnt     <= issue_cnt + 2'd1;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                    if (cap_cnt == 2'd3)
                        state <= ST_XFORM;
                end
                ST_XFORM: begin
                    if (to_shader_valid)
                        proto_err <= 1'b1;
                    out_q      <= map_c;
                    data_ready <= 1'b1;
                    state      <= ST_READY;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign vertice1_x_update     = out_q[0].sx;
    assign vertice1_y_update     = out_q[0].sy;
    assign vertice1_depth_update = out_q[0].depth;
    assign vertice1_color_update = out_q[0].color;
    assign vertice2_x_update     = out_q[1].sx;
    assign vertice2_y_update     = out_q[1].sy;
    assign vertice2_depth_update = out_q[1].depth;
    assign vertice2_color_update = out_q[1].color;
    assign vertice3_x_update     = out_q[2].sx;
    assign vertice3_y_update     = out_q[2].sy;
    assign vertice3_depth_update = out_q[2].depth;
    assign vertice3_color_update = out_q[2].color;

endmodule

// File: tb/tb_vertex_shader.sv
// Bench for vertex_shader: default instance plus a high depth-bias instance
// sharing the same stimulus and SRAM model; triangles scored from a queue.
module tb_vertex_shader;

    localparam int unsigned BIAS_B = 2097052;   // 2^21 - 100

    typedef struct packed {
        logic [2:0][11:0] sx;
        logic [2:0][11:0] sy;
        logic [2:0][20:0] dp;
        logic [2:0][20:0] dpb;
        logic [2:0][23:0] col;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [19:0] info = '0;
    logic [71:0] rdata;

    logic        a_rd, b_rd, a_ready, b_ready, a_perr, b_perr;
    logic [19:0] a_addr, b_addr;
    logic [11:0] a_x [3], a_y [3], b_x [3], b_y [3];
    logic [20:0] a_dp [3], b_dp [3];
    logic [23:0] a_col [3], b_col [3];

    logic [71:0] mem [64];
    logic        d1_v = 1'b0, d2_v = 1'b0;
    logic [19:0] d1_a = '0, d2_a = '0;

    exp_t        exp_q [$];
    exp_t        cur;
    logic [19:0] rd_log [$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    vertex_shader u_dut_a (
        .clk(clk), .rst(rst), .to_shader_valid(valid), .to_shader_vertice_info(info),
        .sram_vtx_rd(a_rd), .sram_vtx_addr(a_addr), .sram_vtx_rdata(rdata),
        .vertice1_x_update(a_x[0]), .vertice1_y_update(a_y[0]),
        .vertice1_depth_update(a_dp[0]), .vertice1_color_update(a_col[0]),
        .vertice2_x_update(a_x[1]), .vertice2_y_update(a_y[1]),
        .vertice2_depth_update(a_dp[1]), .vertice2_color_update(a_col[1]),
        .vertice3_x_update(a_x[2]), .vertice3_y_update(a_y[2]),
        .vertice3_depth_update(a_dp[2]), .vertice3_color_update(a_col[2]),
        .data_ready(a_ready), .proto_err(a_perr)
    );

    vertex_shader #(.DEPTH_BIAS(BIAS_B)) u_dut_b (
        .clk(clk), .rst(rst), .to_shader_valid(valid), .to_shader_vertice_info(info),
        .sram_vtx_rd(b_rd), .sram_vtx_addr(b_addr), .sram_vtx_rdata(rdata),
        .vertice1_x_update(b_x[0]), .vertice1_y_update(b_y[0]),
        .vertice1_depth_update(b_dp[0]), .vertice1_color_update(b_col[0]),
        .vertice2_x_update(b_x[1]), .vertice2_y_update(b_y[1]),
        .vertice2_depth_update(b_dp[1]), .vertice2_color_update(b_col[1]),
        .vertice3_x_update(b_x[2]), .vertice3_y_update(b_y[2]),
        .vertice3_depth_update(b_dp[2]), .vertice3_color_update(b_col[2]),
        .data_ready(b_ready), .proto_err(b_perr)
    );

    // SRAM model: data for a read strobe seen at edge e is on rdata between e+1 and e+2
    always @(posedge clk) begin
        d1_v <= a_rd;
        d1_a <= a_addr;
        d2_v <= d1_v;
        d2_a <= d1_a;
    end
    assign rdata = d2_v ? mem[d2_a[5:0]] : {3{24'h5A5A5A}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [71:0] rec(input int x, input int y, input int z, input int c);
        return {16'(x), 16'(y), 16'(z), 24'(c)};
    endfunction

    task automatic set_v(input int k, input int sx, input int sy, input int dp, input int dpb, input int col);
        cur.sx[k]  = 12'(sx);
        cur.sy[k]  = 12'(sy);
        cur.dp[k]  = 21'(dp);
        cur.dpb[k] = 21'(dpb);
        cur.col[k] = 24'(col);
    endtask

    task automatic drive(input logic [19:0] idx);
        @(negedge clk);
        valid = 1'b1;
        info  = idx;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    // Count rising edges until data_ready, bounded
    task automatic wait_ready(input string name, input int exp_n);
        int n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (a_ready) begin
                n = i;
                break;
            end
        end
        chk(name, 32'(n), 32'(exp_n));
    endtask

    // Log every SRAM read the default instance issues
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (a_rd) rd_log.push_back(a_addr);
        end
    end

    // Scoreboard monitor: score a triangle on each rising data_ready
    initial begin
        logic dr_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                dr_prev = 1'b0;
            end else begin
                if (a_ready && !dr_prev) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL sb_unexpected: got data_ready=1 expected no triangle");
                    end else begin
                        e = exp_q.pop_front();
                        chk("b_ready", 32'(b_ready), 32'd1);
                        for (int k = 0; k < 3; k++) begin
                            chk($sformatf("v%0d_x", k + 1), 32'(a_x[k]), 32'(e.sx[k]));
                            chk($sformatf("v%0d_y", k + 1), 32'(a_y[k]), 32'(e.sy[k]));
                            chk($sformatf("v%0d_depth", k + 1), 32'(a_dp[k]), 32'(e.dp[k]));
                            chk($sformatf("v%0d_color", k + 1), 32'(a_col[k]), 32'(e.col[k]));
                            chk($sformatf("v%0d_depth_bias", k + 1), 32'(b_dp[k]), 32'(e.dpb[k]));
                        end
                    end
                end
                dr_prev = a_ready;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of run expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Reset values
        #3 rst = 1'b1;
        #1;
        chk("rst_rd", 32'(a_rd), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_perr", 32'(a_perr), 32'd0);
        chk("rst_x1", 32'(a_x[0]), 32'd0);
        chk("rst_depth3", 32'(a_dp[2]), 32'd0);
        chk("rst_color2", 32'(a_col[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Origin vertices, consecutive indices
        for (int i = 5; i <= 7; i++) mem[i] = rec(0, 0, 100, 'hFF0000);
        for (int k = 0; k < 3; k++) set_v(k, 320, 240, 100, 2097151, 'hFF0000);
        exp_q.push_back(cur);
        rd_log.delete();
        drive(5); drive(6); drive(7); idle(1);
        wait_ready("lat_basic", 5);
        chk("rd_count_basic", 32'(rd_log.size()), 32'd3);
        for (int k = 0; k < 3 && k < rd_log.size(); k++)
            chk($sformatf("rd_addr%0d", k), 32'(rd_log[k]), 32'(5 + k));

        // Saturation on x/y/depth; new index while READY
        mem[10] = rec(-2000, 5000, 0, 'h0000FF);
        mem[11] = rec(8000, -300, 1, 'h00FF00);
        mem[12] = rec(100, -50, 'hFFFF, 'h123456);
        set_v(0, 0, 4095, 0, 2097052, 'h0000FF);
        set_v(1, 4095, 0, 1, 2097053, 'h00FF00);
        set_v(2, 420, 190, 65535, 2097151, 'h123456);
        exp_q.push_back(cur);
        drive(10);
        @(posedge clk);
        #1;
        chk("ready_drop", 32'(a_ready), 32'd0);
        chk("hold_x1", 32'(a_x[0]), 32'd320);
        chk("hold_depth1", 32'(a_dp[0]), 32'd100);
        drive(11); drive(12); idle(1);
        wait_ready("lat_ready_restart", 5);

        // Fourth index right after the third
        mem[20] = rec(-320, -240, 7, 'hABCDEF);
        mem[21] = rec(3775, 3855, 'h1234, 'h000001);
        mem[22] = rec(-321, -241, 2, 'h777777);
        mem[23] = rec(1, 1, 1, 'h010101);
        set_v(0, 0, 0, 7, 2097059, 'hABCDEF);
        set_v(1, 4095, 4095, 4660, 2097151, 'h000001);
        set_v(2, 0, 0, 2, 2097054, 'h777777);
        exp_q.push_back(cur);
        rd_log.delete();
        drive(20); drive(21); drive(22); drive(23); idle(1);
        chk("perr_set", 32'(a_perr), 32'd1);
        wait_ready("lat_after_extra", 4);
        chk("rd_count_extra", 32'(rd_log.size()), 32'd3);
        if (rd_log.size() == 3) chk("rd_addr_last", 32'(rd_log[2]), 32'd22);

        // Gapped indices
        mem[30] = rec(1, 2, 3, 'h010203);
        mem[31] = rec(-1, -2, 50, 'h0A0B0C);
        mem[32] = rec(3776, 0, 99, 'hFFFFFF);
        set_v(0, 321, 242, 3, 2097055, 'h010203);
        set_v(1, 319, 238, 50, 2097102, 'h0A0B0C);
        set_v(2, 4095, 240, 99, 2097151, 'hFFFFFF);
        exp_q.push_back(cur);
        drive(30); idle(2); drive(31); idle(2); drive(32); idle(1);
        wait_ready("lat_gapped", 5);
        chk("perr_sticky", 32'(a_perr), 32'd1);

        // Reset during fetch with two reads outstanding
        mem[40] = rec(32767, 32767, 'hFFFF, 'hBADBAD);
        mem[41] = rec(32767, 32767, 'hFFFF, 'hBADBAD);
        rd_log.delete();
        drive(40); drive(41);
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        #1;
        chk("mid_rst_x1", 32'(a_x[0]), 32'd0);
        chk("mid_rst_depth3", 32'(a_dp[2]), 32'd0);
        chk("mid_rst_ready", 32'(a_ready), 32'd0);
        chk("mid_rst_perr", 32'(a_perr), 32'd0);
        chk("mid_rst_rd", 32'(a_rd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(8);
        chk("rd_count_partial", 32'(rd_log.size()), 32'd2);
        chk("post_rst_ready", 32'(a_ready), 32'd0);
        chk("post_rst_x1", 32'(a_x[0]), 32'd0);
        mem[40] = rec(10, 20, 30, 'h111111);
        mem[41] = rec(20, 40, 60, 'h222222);
        mem[42] = rec(30, 60, 90, 'h333333);
        set_v(0, 330, 260, 30, 2097082, 'h111111);
        set_v(1, 340, 280, 60, 2097112, 'h222222);
        set_v(2, 350, 300, 90, 2097142, 'h333333);
        exp_q.push_back(cur);
        drive(40); drive(41); drive(42); idle(1);
        wait_ready("lat_after_rst", 5);

        idle(4);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
